alu: RTL and testbench

- Small command-execution ALU inside the UART command processor.
- Takes a decoded command (2-bit opcode, two 3-bit operands) from the UART RX/command decoder with a valid/ack handshake.
- Computes a 6-bit result and pulses start_TX so the UART transmitter sends the result back.
- Single clock domain. Asynchronous, active-high reset.

---
 rtl/alu.sv | 88 ++++++++
 tb/tb_alu.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu.sv
// Command ALU for the UART command processor: latches a decoded command,
// computes a 6-bit result and pulses start_TX. Optional: ALU_DIV_EN (opcode 11 = DIV).
module alu (
    input  logic       clk,
    input  logic       reset,
    input  logic       cmd_valid,
    input  logic [1:0] opcode,
    input  logic [2:0] op1,
    input  logic [2:0] op2,
    output logic       start_TX,
    output logic       cmd_ack,
    output logic [5:0] result
);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        DONE
    } state_t;

    state_t     state;
    logic [1:0] opc_q;
    logic [2:0] a_q;
    logic [2:0] b_q;
    logic [5:0] calc;
    logic [5:0] a6;
    logic [5:0] b6;

    assign a6 = {3'b000, a_q};
    assign b6 = {3'b000, b_q};

    always_comb begin
        calc = 6'd0;
        case (opc_q)
            2'b00: calc = a6 + b6;
            2'b01: calc = a6 - b6;
            2'b10: calc = a6 * b6;
            default: begin
`ifdef ALU_DIV_EN
                // a zero divisor is flagged with the all-ones marker
                if (b_q == 3'd0)
                    calc = 6'h3F;
                else
                    calc = {3'b000, a_q / b_q};
`else
                calc = {3'b000, a_q ^ b_q};
`endif
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            opc_q    <= 2'd0;
            a_q      <= 3'd0;
            b_q      <= 3'd0;
            result   <= 6'd0;
            cmd_ack  <= 1'b0;
            start_TX <= 1'b0;
        end else begin
            cmd_ack  <= 1'b0;
            start_TX <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        opc_q   <= opcode;
                        a_q     <= op1;
                        b_q     <= op2;
                        cmd_ack <= 1'b1;
                        state   <= EXEC;
                    end
                end
                EXEC: begin
                    result   <= calc;
                    start_TX <= 1'b1;
                    state    <= DONE;
                end
                DONE: begin
                    // guard slot: commands arriving here are dropped
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: scoreboard of expected results popped on
// each start_TX, plus handshake timing, back-to-back and reset-abort checks.
module tb_alu;

    logic       clk;
    logic       rst;
    logic       cmd_valid;
    logic [1:0] opcode;
    logic [2:0] op1;
    logic [2:0] op2;
    logic       start_TX;
    logic       cmd_ack;
    logic [5:0] result;

    int total = 0;
    int bad   = 0;

    logic [5:0] exp_q[$];

    alu dut (
        .clk      (clk),
        .reset    (rst),
        .cmd_valid(cmd_valid),
        .opcode   (opcode),
        .op1      (op1),
        .op2      (op2),
        .start_TX (start_TX),
        .cmd_ack  (cmd_ack),
        .result   (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [5:0] model(logic [1:0] op, logic [2:0] a, logic [2:0] b);
        int r;
        case (op)
            2'b00: r = int'(a) + int'(b);
            2'b01: r = int'(a) - int'(b) + 64;
            2'b10: r = int'(a) * int'(b);
            default: begin
`ifdef ALU_DIV_EN
                r = (b == 0) ? 63 : int'(a) / int'(b);
`else
                r = int'(a ^ b);
`endif
            end
        endcase
        return 6'(r % 64);
    endfunction

    // one-cycle cmd_valid pulse; returns at the negedge after the sampling edge
    task automatic issue(input logic [1:0] op, input logic [2:0] a,
                         input logic [2:0] b, input bit push, input logic [5:0] e);
        @(negedge clk);
        opcode    = op;
        op1       = a;
        op2       = b;
        cmd_valid = 1'b1;
        if (push) exp_q.push_back(e);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    // waits (bounded) for start_TX, returns observed and scoreboard values
    task automatic await_tx(output bit ok, output logic [5:0] got,
                            output logic [5:0] want, input bit settle);
        ok = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (start_TX === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        got  = result;
        want = (exp_q.size() > 0) ? exp_q.pop_front() : 6'hxx;
        if (settle) @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        cmd_valid = 1'b0;
        opcode = 2'd0;
        op1 = 3'd0;
        op2 = 3'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++;
        if (result !== 6'd0) begin
            bad++;
            $display("FAIL reset_result got=%0d want=0", result);
        end
        total++;
        if (cmd_ack !== 1'b0 || start_TX !== 1'b0) begin
            bad++;
            $display("FAIL reset_pulses got ack=%b tx=%b want 0 0", cmd_ack, start_TX);
        end
        rst = 1'b0;
    endtask

    task automatic test_add_timing;
        bit ok;
        logic [5:0] got, want;
        @(negedge clk);
        issue(2'b00, 3'd3, 3'd3, 1'b1, 6'b000110);
        total++;
        if (cmd_ack !== 1'b1 || start_TX !== 1'b0) begin
            bad++;
            $display("FAIL ack_cycle got ack=%b tx=%b want 1 0", cmd_ack, start_TX);
        end
        @(negedge clk);
        total++;
        if (cmd_ack !== 1'b0 || start_TX !== 1'b1) begin
            bad++;
            $display("FAIL tx_cycle got ack=%b tx=%b want 0 1", cmd_ack, start_TX);
        end
        await_tx(ok, got, want, 1'b1);
        total++;
        if (!ok || got !== want) begin
            bad++;
            $display("FAIL add_3_3 got=%0d want=%0d ok=%0d", got, want, ok);
        end
        total++;
        if (cmd_ack !== 1'b0 || start_TX !== 1'b0) begin
            bad++;
            $display("FAIL after_tx got ack=%b tx=%b want 0 0", cmd_ack, start_TX);
        end
        total++;
        if (result !== 6'd6) begin
            bad++;
            $display("FAIL result_hold got=%0d want=6", result);
        end
    endtask

    task automatic test_arith;
        bit ok;
        logic [5:0] got, want;
        logic [1:0] ops[6] = '{2'b01, 2'b01, 2'b10, 2'b00, 2'b11, 2'b11};
        logic [2:0] as[6]  = '{3'd2, 3'd5, 3'd7, 3'd7, 3'd6, 3'd5};
        logic [2:0] bs[6]  = '{3'd5, 3'd2, 3'd7, 3'd7, 3'd3, 3'd0};
`ifdef ALU_DIV_EN
        logic [5:0] es[6]  = '{6'd61, 6'd3, 6'd49, 6'd14, 6'd2, 6'd63};
`else
        logic [5:0] es[6]  = '{6'd61, 6'd3, 6'd49, 6'd14, 6'd5, 6'd5};
`endif
        for (int i = 0; i < 6; i++) begin
            issue(ops[i], as[i], bs[i], 1'b1, es[i]);
            await_tx(ok, got, want, 1'b1);
            total++;
            if (!ok || got !== want) begin
                bad++;
                $display("FAIL arith_%0d op=%0d a=%0d b=%0d got=%0d want=%0d ok=%0d",
                         i, ops[i], as[i], bs[i], got, want, ok);
            end
        end
    endtask

    task automatic test_back_to_back;
        int acks = 0, txs = 0, first = -1, second = -1, both = 0;
        logic [5:0] want;
        @(negedge clk);
        opcode = 2'b00;
        op1 = 3'd1;
        op2 = 3'd1;
        cmd_valid = 1'b1;
        exp_q.push_back(6'd2);
        exp_q.push_back(6'd2);
        for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            if (cmd_ack === 1'b1 && start_TX === 1'b1) both++;
            if (cmd_ack === 1'b1) begin
                if (acks == 0) first = c;
                else second = c;
                acks++;
            end
            if (start_TX === 1'b1) begin
                txs++;
                want = (exp_q.size() > 0) ? exp_q.pop_front() : 6'hxx;
                total++;
                if (result !== want) begin
                    bad++;
                    $display("FAIL b2b_result got=%0d want=%0d", result, want);
                end
            end
            if (c == 5) cmd_valid = 1'b0;
        end
        total++;
        if (acks != 2 || second - first != 3) begin
            bad++;
            $display("FAIL b2b_acks got=%0d gap=%0d want 2 gap 3", acks, second - first);
        end
        total++;
        if (txs != 2 || both != 0) begin
            bad++;
            $display("FAIL b2b_tx got=%0d overlap=%0d want 2 overlap 0", txs, both);
        end
        exp_q.delete();
    endtask

    task automatic test_reset_mid;
        int seen = 0;
        issue(2'b10, 3'd7, 3'd5, 1'b0, 6'd0);
        #1 rst = 1'b1;
        #1;
        total++;
        if (result !== 6'd0 || cmd_ack !== 1'b0 || start_TX !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid got r=%0d ack=%b tx=%b want 0 0 0",
                     result, cmd_ack, start_TX);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (start_TX === 1'b1 || cmd_ack === 1'b1) seen++;
        end
        total++;
        if (seen != 0) begin
            bad++;
            $display("FAIL reset_abort got pulses=%0d want 0", seen);
        end
    endtask

    task automatic test_random;
        bit ok;
        logic [5:0] got, want;
        logic [1:0] op;
        logic [2:0] a, b;
        for (int i = 0; i < 24; i++) begin
            op = 2'($urandom_range(0, 3));
            a  = 3'($urandom_range(0, 7));
            b  = 3'($urandom_range(0, 7));
            issue(op, a, b, 1'b1, model(op, a, b));
            await_tx(ok, got, want, 1'b1);
            total++;
            if (!ok || got !== want) begin
                bad++;
                $display("FAIL rand_%0d op=%0d a=%0d b=%0d got=%0d want=%0d ok=%0d",
                         i, op, a, b, got, want, ok);
            end
        end
    endtask

    initial begin
        test_reset;
        test_add_timing;
        test_arith;
        test_back_to_back;
        test_reset_mid;
        test_random;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
